// File: rtl/alu_pkg.sv
// Shared ALU op codes, RV32I encoding constants and the decoded-bundle layout
// used between the issue stage and the ALU.
package alu_pkg;

  localparam logic [3:0] ALU_EQ  = 4'd0;
  localparam logic [3:0] ALU_NE  = 4'd1;
  localparam logic [3:0] ALU_LT  = 4'd2;
  localparam logic [3:0] ALU_GE  = 4'd3;
  localparam logic [3:0] ALU_LTU = 4'd4;
  localparam logic [3:0] ALU_GEU = 4'd5;
  localparam logic [3:0] ALU_ADD = 4'd6;
  localparam logic [3:0] ALU_XOR = 4'd7;
  localparam logic [3:0] ALU_OR  = 4'd8;
  localparam logic [3:0] ALU_AND = 4'd9;
  localparam logic [3:0] ALU_SUB = 4'd10;
  localparam logic [3:0] ALU_SLL = 4'd11;
  localparam logic [3:0] ALU_SRL = 4'd12;
  localparam logic [3:0] ALU_SRA = 4'd13;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [3:0]  aluOp;
    logic [31:0] aluIn0;
    logic [31:0] aluIn1;
    logic [31:0] rs2Out;
    logic [31:0] immOut;
    logic [31:0] pcOut;
    logic [4:0]  rdAddr;
    logic        regWrite;
    logic        isBranch;
    logic        isLoad;
    logic        isStore;
    logic        illegal;
  } decodedT;

  localparam int DEC_W = $bits(decodedT);

endpackage

// File: rtl/alu_issue_stage_imm_gen.sv
// Combinational RV32I immediate extraction (I/S/B/U/J), all sign-extended.
// Opcode bits carry no immediate data, so only instr[31:7] is taken.
module imm_gen (
  input  logic [31:7] instr,
  output logic [31:0] immI,
  output logic [31:0] immS,
  output logic [31:0] immB,
  output logic [31:0] immU,
  output logic [31:0] immJ
);
  assign immI = {{20{instr[31]}}, instr[31:20]};
  assign immS = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign immB = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign immU = {instr[31:12], 12'h000};
  assign immJ = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
endmodule

// File: rtl/alu_issue_stage.sv
// RV32I decode and operand select feeding the ALU through a 2-entry skid
// buffer, so every ALU input and inReady come straight from flops.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  inValid,
  output logic                  inReady,
  input  logic [31:0]           instr,
  input  logic [XLEN-1:0]       pcIn,
  input  logic [XLEN-1:0]       rs1Data,
  input  logic [XLEN-1:0]       rs2Data,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [3:0]            aluOp,
  output logic [XLEN-1:0]       aluIn0,
  output logic [XLEN-1:0]       aluIn1,
  output logic [XLEN-1:0]       rs2Out,
  output logic [XLEN-1:0]       immOut,
  output logic [XLEN-1:0]       pcOut,
  output logic [REG_ADDR_W-1:0] rdAddr,
  output logic                  regWrite,
  output logic                  isBranch,
  output logic                  isLoad,
  output logic                  isStore,
  output logic                  illegal
);
  logic [31:0] immI, immS, immB, immU, immJ;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic        isImm;
  decodedT     decP0, mainP1, skidP1;
  logic        mainVld, skidVld, inReadyQ;
  logic        accept, transfer, mainLoad, skidLoad, mainVldNext, skidVldNext;

  imm_gen uImmGen (
    .instr (instr[31:7]),
    .immI  (immI),
    .immS  (immS),
    .immB  (immB),
    .immU  (immU),
    .immJ  (immJ)
  );

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // Stage p0: combinational decode of the presented instruction
  always_comb begin
    decP0        = '0;
    isImm        = (opcode == OPC_OPIMM);
    decP0.aluOp  = ALU_ADD;
    decP0.rs2Out = rs2Data;
    decP0.pcOut  = pcIn;
    decP0.rdAddr = instr[11:7];
    case (opcode)
      OPC_OP, OPC_OPIMM: begin
        decP0.aluIn0   = rs1Data;
        decP0.aluIn1   = isImm ? immI : rs2Data;
        decP0.immOut   = immI;
        decP0.regWrite = 1'b1;
        case (funct3)
          F3_ADD:  decP0.aluOp = (!isImm && funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
          F3_SLL:  decP0.aluOp = ALU_SLL;
          F3_SLT:  decP0.aluOp = ALU_LT;
          F3_SLTU: decP0.aluOp = ALU_LTU;
          F3_XOR:  decP0.aluOp = ALU_XOR;
          F3_SR:   decP0.aluOp = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
          F3_OR:   decP0.aluOp = ALU_OR;
          default: decP0.aluOp = ALU_AND;
        endcase
        // Only shifts consume funct7 on OP-IMM; the rest carry immediate bits there
        if (!isImm)
          decP0.illegal = !(funct7 == F7_BASE ||
                            (funct7 == F7_ALT && (funct3 == F3_ADD || funct3 == F3_SR)));
        else if (funct3 == F3_SLL)
          decP0.illegal = (funct7 != F7_BASE);
        else if (funct3 == F3_SR)
          decP0.illegal = !(funct7 == F7_BASE || funct7 == F7_ALT);
      end
      OPC_BRANCH: begin
        decP0.aluIn0   = rs1Data;
        decP0.aluIn1   = rs2Data;
        decP0.immOut   = immB;
        decP0.isBranch = 1'b1;
        case (funct3)
          F3_BEQ:  decP0.aluOp = ALU_EQ;
          F3_BNE:  decP0.aluOp = ALU_NE;
          F3_BLT:  decP0.aluOp = ALU_LT;
          F3_BGE:  decP0.aluOp = ALU_GE;
          F3_BLTU: decP0.aluOp = ALU_LTU;
          F3_BGEU: decP0.aluOp = ALU_GEU;
          default: decP0.illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        decP0.aluIn0   = rs1Data;
        decP0.aluIn1   = immI;
        decP0.immOut   = immI;
        decP0.isLoad   = 1'b1;
        decP0.regWrite = 1'b1;
      end
      OPC_STORE: begin
        decP0.aluIn0  = rs1Data;
        decP0.aluIn1  = immS;
        decP0.immOut  = immS;
        decP0.isStore = 1'b1;
      end
      OPC_LUI: begin
        decP0.aluIn1   = immU;
        decP0.immOut   = immU;
        decP0.regWrite = 1'b1;
      end
      OPC_AUIPC: begin
        decP0.aluIn0   = pcIn;
        decP0.aluIn1   = immU;
        decP0.immOut   = immU;
        decP0.regWrite = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        decP0.aluIn0   = pcIn;
        decP0.aluIn1   = 32'd4;
        decP0.immOut   = (opcode == OPC_JAL) ? immJ : immI;
        decP0.regWrite = 1'b1;
      end
      default: decP0.illegal = 1'b1;
    endcase
    // Illegal encodings travel as an inert ADD 0+0 so the ALU never sees garbage
    if (decP0.illegal) begin
      decP0.aluOp    = ALU_ADD;
      decP0.aluIn0   = '0;
      decP0.aluIn1   = '0;
      decP0.regWrite = 1'b0;
      decP0.isBranch = 1'b0;
      decP0.isLoad   = 1'b0;
      decP0.isStore  = 1'b0;
    end
    if (decP0.rdAddr == 5'd0)
      decP0.regWrite = 1'b0;
  end

  always_comb begin
    accept      = inValid && inReadyQ;
    transfer    = mainVld && outReady;
    mainLoad    = accept && (!mainVld || (transfer && !skidVld));
    skidLoad    = accept && !mainLoad;
    mainVldNext = mainVld;
    skidVldNext = skidVld;
    if (transfer) begin
      mainVldNext = skidVld;
      skidVldNext = 1'b0;
    end
    if (mainLoad) mainVldNext = 1'b1;
    if (skidLoad) skidVldNext = 1'b1;
    if (flush) begin
      mainVldNext = 1'b0;
      skidVldNext = 1'b0;
    end
  end

  // Stage p1: main (output) and skid entries
  always_ff @(posedge clk) begin
    if (rst) begin
      mainVld  <= 1'b0;
      skidVld  <= 1'b0;
      inReadyQ <= 1'b1;
      mainP1   <= '0;
      skidP1   <= '0;
    end else begin
      mainVld  <= mainVldNext;
      skidVld  <= skidVldNext;
      inReadyQ <= !skidVldNext;
      if (!flush) begin
        if (transfer && skidVld) mainP1 <= skidP1;
        else if (mainLoad)       mainP1 <= decP0;
        if (skidLoad)            skidP1 <= decP0;
      end
    end
  end

  assign inReady  = inReadyQ;
  assign outValid = mainVld;
  assign aluOp    = mainP1.aluOp;
  assign aluIn0   = mainP1.aluIn0;
  assign aluIn1   = mainP1.aluIn1;
  assign rs2Out   = mainP1.rs2Out;
  assign immOut   = mainP1.immOut;
  assign pcOut    = mainP1.pcOut;
  assign rdAddr   = mainP1.rdAddr;
  assign regWrite = mainP1.regWrite;
  assign isBranch = mainP1.isBranch;
  assign isLoad   = mainP1.isLoad;
  assign isStore  = mainP1.isStore;
  assign illegal  = mainP1.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed-vector bench for alu_issue_stage with a queue scoreboard and an
// independent output monitor.
module tb_alu_issue_stage;
  logic        clk = 1'b0;
  logic        rst, flush, inValid, inReady, outValid, outReady;
  logic [31:0] instr, pcIn, rs1Data, rs2Data;
  logic [3:0]  aluOp;
  logic [31:0] aluIn0, aluIn1, rs2Out, immOut, pcOut;
  logic [4:0]  rdAddr;
  logic        regWrite, isBranch, isLoad, isStore, illegal;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] in0, in1, rs2, imm, pc;
    logic [4:0]  rd;
    logic        rw, br, ld, st, ill, chkImm;
  } expT;

  expT sb[$];
  int  nApplied = 0;
  int  nFail    = 0;

  alu_issue_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .inValid(inValid), .inReady(inReady),
    .instr(instr), .pcIn(pcIn), .rs1Data(rs1Data), .rs2Data(rs2Data),
    .outValid(outValid), .outReady(outReady), .aluOp(aluOp), .aluIn0(aluIn0),
    .aluIn1(aluIn1), .rs2Out(rs2Out), .immOut(immOut), .pcOut(pcOut),
    .rdAddr(rdAddr), .regWrite(regWrite), .isBranch(isBranch), .isLoad(isLoad),
    .isStore(isStore), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nApplied++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic expT mk(input logic [3:0] op, input logic [31:0] i0, input logic [31:0] i1,
                             input logic [4:0] rd, input logic rw, input logic br,
                             input logic ld, input logic st, input logic ill,
                             input logic chkImm, input logic [31:0] imm);
    expT e;
    e.op = op; e.in0 = i0; e.in1 = i1; e.rd = rd; e.rw = rw; e.br = br;
    e.ld = ld; e.st = st; e.ill = ill; e.chkImm = chkImm; e.imm = imm;
    e.rs2 = '0; e.pc = '0;
    return e;
  endfunction

  // Monitor: compares every transfer against the head of the scoreboard
  always @(negedge clk) begin
    if (!rst && outValid && outReady) begin
      if (sb.size() == 0) begin
        nApplied++;
        nFail++;
        $display("FAIL unexpected_output: got aluOp=%0d aluIn0=0x%08h expected no output", aluOp, aluIn0);
      end else begin
        expT e;
        e = sb.pop_front();
        chk("aluOp",    32'(aluOp),    32'(e.op));
        chk("aluIn0",   aluIn0,        e.in0);
        chk("aluIn1",   aluIn1,        e.in1);
        chk("rs2Out",   rs2Out,        e.rs2);
        chk("pcOut",    pcOut,         e.pc);
        chk("rdAddr",   32'(rdAddr),   32'(e.rd));
        chk("regWrite", 32'(regWrite), 32'(e.rw));
        chk("isBranch", 32'(isBranch), 32'(e.br));
        chk("isLoad",   32'(isLoad),   32'(e.ld));
        chk("isStore",  32'(isStore),  32'(e.st));
        chk("illegal",  32'(illegal),  32'(e.ill));
        if (e.chkImm) chk("immOut", immOut, e.imm);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge
  task automatic send(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] a,
                      input logic [31:0] b, input expT e, input logic doPush);
    int  waited = 0;
    logic rdy;
    instr = ins; pcIn = pc; rs1Data = a; rs2Data = b; inValid = 1'b1;
    forever begin
      rdy = inReady;
      @(posedge clk); #1;
      if (rdy) break;
      waited++;
      if (waited > 50) begin
        nApplied++;
        nFail++;
        $display("FAIL send_timeout: got inReady=0 for 50 cycles expected acceptance");
        break;
      end
    end
    if (doPush && rdy) begin
      e.rs2 = b;
      e.pc  = pc;
      sb.push_back(e);
    end
    inValid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; inValid = 1'b0; outReady = 1'b1;
    instr = '0; pcIn = '0; rs1Data = '0; rs2Data = '0;
    idle(3);
    chk("rst_outValid", 32'(outValid), 32'd0);
    chk("rst_inReady",  32'(inReady),  32'd1);
    chk("rst_aluIn0",   aluIn0,        32'd0);
    chk("rst_illegal",  32'(illegal),  32'd0);
    rst = 1'b0;

    // add x3,x1,x2: visible one edge after acceptance
    send(32'h002081B3, 32'h0, 32'd5, 32'd7, mk(4'd6, 32'd5, 32'd7, 5'd3, 1, 0, 0, 0, 0, 0, 0), 1);
    chk("latency_outValid", 32'(outValid), 32'd1);
    // srai x1,x1,3
    send(32'h4030D093, 32'h4, 32'h80000000, 32'h0, mk(4'd13, 32'h80000000, 32'h403, 5'd1, 1, 0, 0, 0, 0, 0, 0), 1);
    // bltu x1,x2,+8
    send(32'h0020E463, 32'h8, 32'd3, 32'd9, mk(4'd4, 32'd3, 32'd9, 5'd8, 0, 1, 0, 0, 0, 1, 32'd8), 1);
    // unknown opcode 0x7F, then OP with funct7=0000001
    send(32'h0000007F, 32'hC, 32'h11, 32'h22, mk(4'd6, 0, 0, 5'd0, 0, 0, 0, 0, 1, 0, 0), 1);
    send(32'h022081B3, 32'h10, 32'h11, 32'h22, mk(4'd6, 0, 0, 5'd3, 0, 0, 0, 0, 1, 0, 0), 1);
    // auipc x5,0x1 @0x100 and jal x1,+16 @0x200
    send(32'h00001297, 32'h100, 32'h0, 32'h0, mk(4'd6, 32'h100, 32'h1000, 5'd5, 1, 0, 0, 0, 0, 1, 32'h1000), 1);
    send(32'h010000EF, 32'h200, 32'h0, 32'h0, mk(4'd6, 32'h200, 32'd4, 5'd1, 1, 0, 0, 0, 0, 1, 32'd16), 1);
    // sub, addi x0 (regWrite suppressed), lw -4, sw +8, lui
    send(32'h40208233, 32'h14, 32'd9, 32'd4, mk(4'd10, 32'd9, 32'd4, 5'd4, 1, 0, 0, 0, 0, 0, 0), 1);
    send(32'h00100013, 32'h18, 32'd2, 32'd0, mk(4'd6, 32'd2, 32'd1, 5'd0, 0, 0, 0, 0, 0, 0, 0), 1);
    send(32'hFFC12303, 32'h1C, 32'h1000, 32'd0, mk(4'd6, 32'h1000, 32'hFFFFFFFC, 5'd6, 1, 0, 1, 0, 0, 1, 32'hFFFFFFFC), 1);
    send(32'h0050A423, 32'h20, 32'h2000, 32'h55, mk(4'd6, 32'h2000, 32'd8, 5'd8, 0, 0, 0, 1, 0, 1, 32'd8), 1);
    send(32'hABCDE3B7, 32'h24, 32'h77, 32'd0, mk(4'd6, 32'h0, 32'hABCDE000, 5'd7, 1, 0, 0, 0, 0, 0, 0), 1);
    // slli with funct7=0100000, and branch funct3=010: both illegal
    send(32'h40109093, 32'h28, 32'h5, 32'd0, mk(4'd6, 0, 0, 5'd1, 0, 0, 0, 0, 1, 0, 0), 1);
    send(32'h0020A463, 32'h2C, 32'h5, 32'h6, mk(4'd6, 0, 0, 5'd8, 0, 0, 0, 0, 1, 0, 0), 1);
    idle(3);

    // Backpressure: A held on output, B in skid, C stalled
    outReady = 1'b0;
    send(32'h002081B3, 32'h300, 32'hA, 32'h1, mk(4'd6, 32'hA, 32'h1, 5'd3, 1, 0, 0, 0, 0, 0, 0), 1);
    send(32'h40208233, 32'h304, 32'hB, 32'h2, mk(4'd10, 32'hB, 32'h2, 5'd4, 1, 0, 0, 0, 0, 0, 0), 1);
    chk("skid_full_inReady", 32'(inReady), 32'd0);
    instr = 32'h0020C4B3; pcIn = 32'h308; rs1Data = 32'hC; rs2Data = 32'h3; inValid = 1'b1;
    repeat (2) begin
      idle(1);
      chk("stall_inReady", 32'(inReady), 32'd0);
      chk("hold_aluIn0",   aluIn0,       32'hA);
    end
    outReady = 1'b1;
    send(32'h0020C4B3, 32'h308, 32'hC, 32'h3, mk(4'd7, 32'hC, 32'h3, 5'd9, 1, 0, 0, 0, 0, 0, 0), 1);
    idle(4);

    // Flush with both entries full and a pending instruction
    outReady = 1'b0;
    send(32'h002081B3, 32'h400, 32'hDEAD, 32'h1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0);
    send(32'h40208233, 32'h404, 32'hBEEF, 32'h2, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0);
    instr = 32'h0020C4B3; pcIn = 32'h408; inValid = 1'b1; flush = 1'b1;
    idle(1);
    flush = 1'b0; inValid = 1'b0;
    chk("flush_outValid", 32'(outValid), 32'd0);
    chk("flush_inReady",  32'(inReady),  32'd1);
    // Flush with one entry and a concurrent accept into skid
    send(32'h002081B3, 32'h500, 32'h1, 32'h1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0);
    instr = 32'h40208233; pcIn = 32'h504; inValid = 1'b1; flush = 1'b1;
    idle(1);
    flush = 1'b0; inValid = 1'b0; outReady = 1'b1;
    chk("flush2_outValid", 32'(outValid), 32'd0);
    idle(3);
    chk("postflush_outValid", 32'(outValid), 32'd0);

    // Reset while an illegal entry sits on the output
    outReady = 1'b0;
    send(32'h0000007F, 32'h600, 32'h11, 32'h22, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0);
    chk("pre_rst_illegal", 32'(illegal), 32'd1);
    outReady = 1'b1; rst = 1'b1;
    idle(1);
    outReady = 1'b0;
    chk("midrst_outValid", 32'(outValid), 32'd0);
    chk("midrst_inReady",  32'(inReady),  32'd1);
    chk("midrst_illegal",  32'(illegal),  32'd0);
    chk("midrst_pcOut",    pcOut,         32'd0);
    chk("midrst_rs2Out",   rs2Out,        32'd0);
    rst = 1'b0;
    outReady = 1'b1;

    // Everything pushed must have been delivered
    for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nApplied, nFail);
    $finish;
  end

endmodule
